proc_ctrl: RTL
==============

# proc_ctrl

Control unit for the 9-bit multi-cycle processor datapath. It sequences a shared bus, eight general registers R0–R7, the A/G adder registers and the instruction register, all built from the 9-bit `regn` register. It steps through time steps T0–T3 per instruction and emits one-hot register load and bus-drive enables, so that exactly one source drives the bus in any cycle. It decodes four opcodes (mv, mvi, add, sub) and signals completion with `Done`.

## Interface
Parameters:
- `NREG`, 8: number of general registers. Sets the width of `Rin`/`Rout`; register fields are 3 bits.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Run`  in  1  start request, sampled in T0.
- `IR`  in  9  instruction register contents: `IR[8:6]`=opcode III, `IR[5:3]`=XXX (destination/first operand), `IR[2:0]`=YYY (source).
- `IRin`  out  1  load enable for the instruction register (loads from DIN).
- `Rin`  out  NREG  one-hot load enables for R0–R7.
- `Rout`  out  NREG  one-hot bus-drive selects for R0–R7.
- `DINout`  out  1  DIN drives the bus.
- `Gout`  out  1  G drives the bus.
- `Ain`  out  1  load enable for A.
- `Gin`  out  1  load enable for G.
- `AddSub`  out  1  adder mode: 0 = A+bus, 1 = A−bus.
- `Done`  out  1  final cycle of the current instruction.
- `Busy`  out  1  high whenever the step is not T0.

## Operation
- State: 2-bit time-step counter `Tstep` ∈ {T0, T1, T2, T3}. Control outputs are combinational from `Tstep` and `IR`.
- Opcodes: 000 mv Rx←Ry; 001 mvi Rx←DIN; 010 add Rx←Rx+Ry; 011 sub Rx←Rx−Ry; 100–111 reserved (no-op).
- T0: `IRin`=1. Transition: if `Run`=1 then T1, else stay in T0.
- T1:
  - mv: `Rout[Y]`=1, `Rin[X]`=1, `Done`=1.
  - mvi: `DINout`=1, `Rin[X]`=1, `Done`=1.
  - add/sub: `Rout[X]`=1, `Ain`=1.
  - reserved: `Done`=1 only, no enables.
- T2 (add/sub only): `Rout[Y]`=1, `Gin`=1, `AddSub`=(opcode==011).
- T3 (add/sub only): `Gout`=1, `Rin[X]`=1, `Done`=1, `AddSub` held at the T2 value.
- Any cycle with `Done`=1 transitions to T0. Otherwise the step advances T1→T2→T3.
- Invariant: at most one of {`Rout[*]`, `DINout`, `Gout`} is high in any cycle. `Rin` and `Rout` are each zero or one-hot.
- mv with X==Y is legal: Rx is reloaded with itself.
- add/sub with X==Y is legal: Rx←2Rx or 0. Adder arithmetic is modulo 2^9 and handled in the datapath.
- `Busy` = (`Tstep` != T0).

## Timing
- Reset: `Tstep`=T0 at the next edge. While `Reset`=1, every output is forced to 0, including `IRin`, `Done` and `Busy`.
- Reset during T1–T3: the instruction is aborted and no `Rin`/`Gin`/`Ain` is asserted in the reset cycle. After `Reset` falls, the block is in T0 and needs `Run` again.
- Latency from the T0 edge that samples `Run`=1:
  - mv, mvi, reserved: `Done` in the following cycle (T1). Total 2 cycles including T0.
  - add, sub: `Done` in T3. Total 4 cycles.
- `Run` is ignored outside T0. Back-to-back instructions: with `Run` held high, T0 follows `Done` directly, so there is one IR-load cycle between instructions.
- mvi: the immediate must be on DIN during T1. The instruction word must be on DIN during T0.
- `IR` is read only in T1–T3 and must be stable there. `IRin` is never asserted outside T0.

## Test plan
1. Reset held 2 cycles in T2 of an add → all outputs 0 in both cycles. The cycle after release shows `Tstep`=T0, `IRin`=1, `Busy`=0, and no `Rin` bit was ever set.
2. `Run`=1 with IR=001_011_000 (mvi R3) → next cycle `DINout`=1, `Rin`=00001000, `Done`=1, `Rout`=0. The cycle after that is T0.
3. IR=000_010_101 (mv R2,R5) → T1: `Rout`=00100000, `Rin`=00000100, `Done`=1.
4. IR=011_001_110 (sub R1,R6):
   - T1: `Rout`=00000010, `Ain`=1.
   - T2: `Rout`=01000000, `Gin`=1, `AddSub`=1.
   - T3: `Gout`=1, `Rin`=00000010, `Done`=1.
   - Repeat with opcode 010 → `AddSub`=0.
5. `Run`=0 held 5 cycles → stays in T0, `IRin`=1 each cycle, `Busy`=0. Toggling `Run` during T1–T3 of an add does not change the step sequence.
6. IR=110_xxx_xxx (reserved) → T1: `Done`=1, all enables 0, then T0. A bus-exclusivity assertion over a random instruction stream never fires.

Source files
------------

// File: rtl/proc_ctrl.sv
// Control unit for the 9-bit multi-cycle processor: steps T0..T3 per instruction
// and drives one-hot register load / bus-drive enables for mv, mvi, add and sub.
module proc_ctrl #(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            Run,
    input  logic [8:0]      IR,
    output logic            IRin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            DINout,
    output logic            Gout,
    output logic            Ain,
    output logic            Gin,
    output logic            AddSub,
    output logic            Done,
    output logic            Busy,
    output logic [1:0]      Tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    tstep_e tstep_q, tstep_d;

    logic [2:0]      op;
    logic [NREG-1:0] x_oh, y_oh;

    assign op   = IR[8:6];
    assign x_oh = NREG'(1) << IR[5:3];
    assign y_oh = NREG'(1) << IR[2:0];

    always_ff @(posedge clk) begin
        if (Reset) tstep_q <= T0;
        else       tstep_q <= tstep_d;
    end

    always_comb begin
        tstep_d = tstep_q;
        IRin    = 1'b0;
        Rin     = '0;
        Rout    = '0;
        DINout  = 1'b0;
        Gout    = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;

        unique case (tstep_q)
            T0: begin
                IRin = 1'b1;
                if (Run) tstep_d = T1;
            end
            T1: begin
                unique case (op)
                    OP_MV: begin
                        Rout = y_oh;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = x_oh;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = x_oh;
                        Ain  = 1'b1;
                    end
                    default: Done = 1'b1;
                endcase
                tstep_d = Done ? T0 : T2;
            end
            T2: begin
                Rout    = y_oh;
                Gin     = 1'b1;
                AddSub  = (op == OP_SUB);
                tstep_d = T3;
            end
            T3: begin
                Gout    = 1'b1;
                Rin     = x_oh;
                AddSub  = (op == OP_SUB);
                Done    = 1'b1;
                tstep_d = T0;
            end
            default: tstep_d = T0;
        endcase

        // Reset silences every enable in the same cycle so an aborted
        // instruction cannot write any register.
        if (Reset) begin
            IRin   = 1'b0;
            Rin    = '0;
            Rout   = '0;
            DINout = 1'b0;
            Gout   = 1'b0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            AddSub = 1'b0;
            Done   = 1'b0;
        end
    end

    assign Busy  = !Reset && (tstep_q != T0);
    assign Tstep = Reset ? 2'd0 : tstep_q;

endmodule
